// File: rtl/trophy_pkg.sv
// Shared types and constants for the trophy manager.
// Contents: FSM state enum, LFSR reset value, Galois feedback mask,
// default grid limits and the off-grid sentinel pattern.
package trophy_pkg;
  typedef enum logic [1:0] {IDLE, PLACE, ACTIVE, DONE} state_e;

  localparam logic [15:0] LFSR_RESET  = 16'hACE1;
  // Right-shift Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] GALOIS_MASK = 16'hB400;

  localparam int unsigned ROW_MAX_DEF = 15;
  localparam int unsigned COL_MAX_DEF = 23;

  // Off-grid marker; slices of this fill empty slots
  localparam logic [15:0] SENTINEL = 16'hFFFF;
endpackage

// File: rtl/trophy_manager_lfsr16.sv
// lfsr16: 16-bit Galois LFSR, steps every clock, loadable.
// Ports:
//   clk_i   clock
//   rst_i   async active-low reset (loads LFSR_RESET)
//   load_i  load seed_i this cycle instead of stepping (zero seed maps to 1)
//   seed_i  seed value
//   lfsr_o  current register value
module lfsr16 import trophy_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] lfsr_o
);
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    if (load_i)         lfsr_d = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
    else if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ GALOIS_MASK;
    else                lfsr_d = lfsr_q >> 1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr_q <= LFSR_RESET;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/trophy_manager.sv
// trophy_manager: places NUM_TROPHY collectibles at distinct random grid
// cells, clears each when the player steps on it, and keeps score.
// Optional feature macro: TROPHY_RESPAWN_EN (per-slot respawn timers).
// Ports:
//   clk_i, rst_i             clock, async active-low reset
//   game_start_i             1-cycle pulse, (re)start a round
//   seed_i                   LFSR seed sampled on game_start_i
//   player_row_i/col_i       current player cell
//   alive_o                  bit i = slot i present
//   trophy_row_o/col_o       flattened slot cells, slot i at [i*W +: W]
//   collect_pulse_o/idx_o    1-cycle collection pulse and slot index
//   score_o                  saturating collection count for this round
//   busy_o                   FSM in PLACE
//   all_collected_o          round complete (level)
module trophy_manager import trophy_pkg::*; #(
  parameter int unsigned NUM_TROPHY     = 3,
  parameter int unsigned ROW_W          = 5,
  parameter int unsigned COL_W          = 5,
  parameter int unsigned ROW_MAX        = ROW_MAX_DEF,
  parameter int unsigned COL_MAX        = COL_MAX_DEF,
  parameter int unsigned SCORE_W        = 8,
  parameter int unsigned RESPAWN_CYCLES = 1000,
  localparam int unsigned IDX_W = (NUM_TROPHY > 1) ? $clog2(NUM_TROPHY) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        game_start_i,
  input  logic [15:0]                 seed_i,
  input  logic [ROW_W-1:0]            player_row_i,
  input  logic [COL_W-1:0]            player_col_i,
  output logic [NUM_TROPHY-1:0]       alive_o,
  output logic [NUM_TROPHY*ROW_W-1:0] trophy_row_o,
  output logic [NUM_TROPHY*COL_W-1:0] trophy_col_o,
  output logic                        collect_pulse_o,
  output logic [IDX_W-1:0]            collect_idx_o,
  output logic [SCORE_W-1:0]          score_o,
  output logic                        busy_o,
  output logic                        all_collected_o
);
  localparam logic [ROW_W-1:0] ROW_SENT = SENTINEL[ROW_W-1:0];
  localparam logic [COL_W-1:0] COL_SENT = SENTINEL[COL_W-1:0];
  localparam logic [ROW_W-1:0] RMAX     = ROW_W'(ROW_MAX);
  localparam logic [COL_W-1:0] CMAX     = COL_W'(COL_MAX);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_TROPHY - 1);
  localparam logic [31:0]      RESP_C   = RESPAWN_CYCLES;

  state_e                               state_q, state_d;
  logic [NUM_TROPHY-1:0]                alive_q, alive_d;
  logic [NUM_TROPHY-1:0][ROW_W-1:0]     row_q, row_d;
  logic [NUM_TROPHY-1:0][COL_W-1:0]     col_q, col_d;
  logic [IDX_W-1:0]                     ptr_q, ptr_d, idx_q, idx_d, hit_idx;
  logic [SCORE_W-1:0]                   score_q, score_d;
  logic                                 pulse_q, pulse_d, done_q, done_d;
  logic [NUM_TROPHY-1:0]                occ, hit;
  logic                                 hit_any, accept, place_last;
  logic [15:0]                          lfsr;
  logic [ROW_W-1:0]                     cand_row;
  logic [COL_W-1:0]                     cand_col;
  logic                                 unused_cfg;

  lfsr16 u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (game_start_i),
    .seed_i (seed_i),
    .lfsr_o (lfsr)
  );

  assign cand_row   = lfsr[ROW_W-1:0];
  assign cand_col   = lfsr[ROW_W +: COL_W];
  assign unused_cfg = ^{lfsr, RESP_C[0]};

  for (genvar g = 0; g < NUM_TROPHY; g++) begin : g_slot
    assign occ[g] = alive_q[g] && (row_q[g] == cand_row) && (col_q[g] == cand_col);
    assign hit[g] = alive_q[g] && (row_q[g] == player_row_i) && (col_q[g] == player_col_i);
  end

  assign accept = (cand_row <= RMAX) && (cand_col <= CMAX) && !(|occ) &&
                  !((cand_row == player_row_i) && (cand_col == player_col_i));

  // Lowest-index match wins
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_TROPHY - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

`ifdef TROPHY_RESPAWN_EN
  localparam int unsigned TMR_W = $clog2(RESPAWN_CYCLES + 1);

  logic [NUM_TROPHY-1:0][TMR_W-1:0] tmr_q;
  logic [NUM_TROPHY-1:0]            run_q, req_q, coll_set, req_clr;
  logic                             respawn_q, respawn_d, req_any;
  logic [IDX_W-1:0]                 req_idx;

  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int i = NUM_TROPHY - 1; i >= 0; i--) begin
      if (req_q[i]) begin
        req_any = 1'b1;
        req_idx = IDX_W'(i);
      end
    end
  end

  // Countdown from collection; the request rises RESPAWN_CYCLES clocks later
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmr_q     <= '0;
      run_q     <= '0;
      req_q     <= '0;
      respawn_q <= 1'b0;
    end else begin
      respawn_q <= respawn_d;
      for (int i = 0; i < NUM_TROPHY; i++) begin
        if (game_start_i) begin
          tmr_q[i] <= '0;
          run_q[i] <= 1'b0;
          req_q[i] <= 1'b0;
        end else begin
          if (coll_set[i]) begin
            tmr_q[i] <= TMR_W'(RESPAWN_CYCLES);
            run_q[i] <= 1'b1;
          end else if (run_q[i]) begin
            if (tmr_q[i] == TMR_W'(1)) begin
              run_q[i] <= 1'b0;
              req_q[i] <= 1'b1;
            end else begin
              tmr_q[i] <= tmr_q[i] - TMR_W'(1);
            end
          end
          if (req_clr[i]) req_q[i] <= 1'b0;
        end
      end
    end
  end

  // A respawn placement fills only one slot
  assign place_last = respawn_q || (ptr_q == LAST);
`else
  assign place_last = (ptr_q == LAST);
`endif

  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    row_d   = row_q;
    col_d   = col_q;
    ptr_d   = ptr_q;
    score_d = score_q;
    pulse_d = 1'b0;
    idx_d   = idx_q;
    done_d  = done_q;
`ifdef TROPHY_RESPAWN_EN
    coll_set  = '0;
    req_clr   = '0;
    respawn_d = respawn_q;
`endif
    if (game_start_i) begin
      state_d = PLACE;
      alive_d = '0;
      score_d = '0;
      done_d  = 1'b0;
      row_d   = {NUM_TROPHY{ROW_SENT}};
      col_d   = {NUM_TROPHY{COL_SENT}};
      ptr_d   = '0;
`ifdef TROPHY_RESPAWN_EN
      respawn_d = 1'b0;
`endif
    end else begin
      case (state_q)
        PLACE: begin
          if (accept) begin
            row_d[ptr_q]   = cand_row;
            col_d[ptr_q]   = cand_col;
            alive_d[ptr_q] = 1'b1;
            ptr_d          = ptr_q + IDX_W'(1);
            if (place_last) begin
              state_d = ACTIVE;
`ifdef TROPHY_RESPAWN_EN
              respawn_d = 1'b0;
`endif
            end
          end
        end
        ACTIVE: begin
          if (hit_any) begin
            alive_d[hit_idx] = 1'b0;
            row_d[hit_idx]   = ROW_SENT;
            col_d[hit_idx]   = COL_SENT;
            pulse_d          = 1'b1;
            idx_d            = hit_idx;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
`ifdef TROPHY_RESPAWN_EN
            coll_set[hit_idx] = 1'b1;
`else
            if (alive_d == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
`endif
          end
`ifdef TROPHY_RESPAWN_EN
          if (req_any) begin
            state_d          = PLACE;
            ptr_d            = req_idx;
            respawn_d        = 1'b1;
            req_clr[req_idx] = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      alive_q <= '0;
      row_q   <= {NUM_TROPHY{ROW_SENT}};
      col_q   <= {NUM_TROPHY{COL_SENT}};
      ptr_q   <= '0;
      score_q <= '0;
      pulse_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ptr_q   <= ptr_d;
      score_q <= score_d;
      pulse_q <= pulse_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign alive_o         = alive_q;
  assign trophy_row_o    = row_q;
  assign trophy_col_o    = col_q;
  assign collect_pulse_o = pulse_q;
  assign collect_idx_o   = idx_q;
  assign score_o         = score_q;
  assign busy_o          = (state_q == PLACE);
  assign all_collected_o = done_q;
endmodule

// File: tb/tb_trophy_manager.sv
module tb_trophy_manager;
  localparam int N = 3, RW = 5, CW = 5, SW = 8, IW = 2;

  logic          clk = 1'b0, rst = 1'b0, gs = 1'b0;
  logic [15:0]   seed = '0;
  logic [RW-1:0] prow = '0;
  logic [CW-1:0] pcol = '0;
  logic [N-1:0]    alive;
  logic [N*RW-1:0] trow;
  logic [N*CW-1:0] tcol;
  logic            cp, busy, allc;
  logic [IW-1:0]   cidx;
  logic [SW-1:0]   score;

  int n_chk = 0, n_fail = 0;
  int exp_row[N], exp_col[N];
  int exp_cycles;

  always #5 clk = ~clk;

  trophy_manager dut (
    .clk_i(clk), .rst_i(rst), .game_start_i(gs), .seed_i(seed),
    .player_row_i(prow), .player_col_i(pcol),
    .alive_o(alive), .trophy_row_o(trow), .trophy_col_o(tcol),
    .collect_pulse_o(cp), .collect_idx_o(cidx), .score_o(score),
    .busy_o(busy), .all_collected_o(allc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Galois step for x^16+x^14+x^13+x^11+1
  function automatic int lfsr_next(input int s);
    return (s % 2 == 1) ? ((s / 2) ^ 32'hB400) : (s / 2);
  endfunction

  // Expected placement: walk the random sequence from the seed, applying the acceptance rules
  task automatic model_place(input int s, input int pr, input int pc);
    int l, placed, r, c;
    bit ok;
    l = (s == 0) ? 1 : s;
    placed = 0;
    exp_cycles = 0;
    while (placed < N) begin
      r = l % 32;
      c = (l / 32) % 32;
      exp_cycles++;
      ok = (r <= 15) && (c <= 23) && !(r == pr && c == pc);
      for (int j = 0; j < placed; j++)
        if (exp_row[j] == r && exp_col[j] == c) ok = 0;
      if (ok) begin
        exp_row[placed] = r;
        exp_col[placed] = c;
        placed++;
      end
      l = lfsr_next(l);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick;
    n_chk++; if (alive !== '0) begin n_fail++; $display("FAIL reset_alive got %b exp 0", alive); end
    n_chk++; if (trow !== '1 || tcol !== '1) begin n_fail++; $display("FAIL reset_sentinel got %h/%h exp all ones", trow, tcol); end
    n_chk++; if (score !== '0 || busy !== 1'b0 || allc !== 1'b0 || cp !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags score=%0d busy=%b allc=%b cp=%b exp 0", score, busy, allc, cp); end
    rst = 1'b1;
    repeat (3) tick;
    n_chk++; if (busy !== 1'b0 || alive !== '0) begin n_fail++; $display("FAIL idle_hold busy=%b alive=%b exp 0", busy, alive); end
  endtask

  task automatic test_place(input int s, input int pr, input int pc);
    int cnt, pulses;
    prow = RW'(pr); pcol = CW'(pc); seed = 16'(s);
    gs = 1'b1; tick; gs = 1'b0;
    model_place(s, pr, pc);
    n_chk++; if (busy !== 1'b1 || alive !== '0 || score !== '0 || allc !== 1'b0) begin
      n_fail++; $display("FAIL start_state busy=%b alive=%b score=%0d allc=%b exp 1/0/0/0", busy, alive, score, allc); end
    cnt = 0; pulses = 0;
    while (busy === 1'b1 && cnt < 300) begin
      tick; cnt++;
      if (cp === 1'b1) pulses++;
    end
    n_chk++; if (cnt !== exp_cycles) begin n_fail++; $display("FAIL place_cycles seed=%h got %0d exp %0d", s, cnt, exp_cycles); end
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL place_no_pulse got %0d exp 0", pulses); end
    n_chk++; if (alive !== '1) begin n_fail++; $display("FAIL place_alive got %b exp 111", alive); end
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (trow[i*RW +: RW] !== RW'(exp_row[i]) || tcol[i*CW +: CW] !== CW'(exp_col[i])) begin
        n_fail++;
        $display("FAIL place_slot%0d seed=%h got (%0d,%0d) exp (%0d,%0d)", i, s,
                 trow[i*RW +: RW], tcol[i*CW +: CW], exp_row[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_collect;
    int pulses;
    test_place(32'h1234, 0, 0);
    prow = RW'(exp_row[1]); pcol = CW'(exp_col[1]);
    tick;
    n_chk++; if (cp !== 1'b1 || cidx !== 2'd1) begin n_fail++; $display("FAIL collect1_pulse cp=%b idx=%0d exp 1/1", cp, cidx); end
    n_chk++; if (score !== 8'd1 || alive !== 3'b101) begin n_fail++; $display("FAIL collect1_state score=%0d alive=%b exp 1/101", score, alive); end
    n_chk++; if (trow[RW +: RW] !== '1 || tcol[CW +: CW] !== '1) begin n_fail++; $display("FAIL collect1_sentinel got (%0d,%0d)", trow[RW +: RW], tcol[CW +: CW]); end
    pulses = 0;
    repeat (10) begin tick; if (cp === 1'b1) pulses++; end
    n_chk++; if (pulses !== 0 || score !== 8'd1) begin n_fail++; $display("FAIL hold_no_repeat pulses=%0d score=%0d exp 0/1", pulses, score); end
    prow = RW'(exp_row[0]); pcol = CW'(exp_col[0]);
    tick;
    n_chk++; if (cp !== 1'b1 || cidx !== 2'd0 || score !== 8'd2 || allc !== 1'b0) begin
      n_fail++; $display("FAIL collect0 cp=%b idx=%0d score=%0d allc=%b exp 1/0/2/0", cp, cidx, score, allc); end
    prow = RW'(exp_row[2]); pcol = CW'(exp_col[2]);
    tick;
    n_chk++; if (cp !== 1'b1 || cidx !== 2'd2 || score !== 8'd3 || alive !== '0 || allc !== 1'b1) begin
      n_fail++; $display("FAIL collect2 cp=%b idx=%0d score=%0d alive=%b allc=%b exp 1/2/3/000/1", cp, cidx, score, alive, allc); end
    pulses = 0;
    repeat (5) begin tick; if (cp === 1'b1) pulses++; end
    n_chk++; if (allc !== 1'b1 || pulses !== 0 || score !== 8'd3) begin
      n_fail++; $display("FAIL done_hold allc=%b pulses=%0d score=%0d exp 1/0/3", allc, pulses, score); end
  endtask

  task automatic test_reset_mid_place;
    prow = '0; pcol = '0; seed = 16'h1234;
    gs = 1'b1; tick; gs = 1'b0;
    tick;
    #2 rst = 1'b0;
    #1;
    n_chk++; if (alive !== '0 || busy !== 1'b0 || score !== '0 || allc !== 1'b0 || trow !== '1 || tcol !== '1) begin
      n_fail++; $display("FAIL async_reset alive=%b busy=%b score=%0d rows=%h cols=%h", alive, busy, score, trow, tcol); end
    @(negedge clk); rst = 1'b1;
    tick;
    test_place(32'h1234, 0, 0);
  endtask

  task automatic test_random_rounds;
    int s, pr, pc, t, j, exp_score;
    int ord[N];
    logic [N-1:0] exp_alive;
    for (int r = 0; r < 6; r++) begin
      s  = (r == 0) ? 0 : int'($urandom_range(1, 16'hFFFF));
      pr = int'($urandom_range(0, 15));
      pc = int'($urandom_range(0, 23));
      test_place(s, pr, pc);
      for (int i = 0; i < N; i++) ord[i] = i;
      for (int i = N - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      exp_alive = '1; exp_score = 0;
      for (int k = 0; k < N; k++) begin
        prow = RW'(exp_row[ord[k]]); pcol = CW'(exp_col[ord[k]]);
        tick;
        exp_alive[ord[k]] = 1'b0; exp_score++;
        n_chk++;
        if (cp !== 1'b1 || cidx !== IW'(ord[k]) || score !== SW'(exp_score) || alive !== exp_alive) begin
          n_fail++;
          $display("FAIL rand_collect r=%0d k=%0d cp=%b idx=%0d score=%0d alive=%b exp idx=%0d score=%0d alive=%b",
                   r, k, cp, cidx, score, alive, ord[k], exp_score, exp_alive);
        end
        prow = RW'(pr); pcol = CW'(pc);
        tick;
        n_chk++; if (cp !== 1'b0) begin n_fail++; $display("FAIL rand_pulse_width r=%0d k=%0d got 1 exp 0", r, k); end
      end
      n_chk++; if (allc !== 1'b1) begin n_fail++; $display("FAIL rand_done r=%0d got %b exp 1", r, allc); end
    end
  endtask

  initial begin
    test_reset;
    test_collect;
    test_place(32'h1234, 0, 0);
    test_reset_mid_place;
    test_place(32'h0000, 3, 4);
    test_random_rounds;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
